delay_stats_acc: RTL and testbench

- Parametrised statistics engine for the delay-measurement path.
- Accepts a stream of delay samples from the timer block. Accumulates exactly 2^LOG2_N samples per run and reports average, minimum, maximum and sample count.
- Adds three things to the earlier fixed 1024-sample logic: a per-run inactivity timeout with an error flag, an explicit start/busy/done handshake, and a selectable display output for the 4-digit display driver.

---
 rtl/delay_stats_acc.sv | 129 ++++++++++++
 tb/tb_delay_stats_acc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_stats_acc.sv
// rtl/delay_stats_acc.sv - delay sample statistics engine (avg/min/max/count, timeout, display mux)
module delay_stats_acc #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOG2_N      = 10,
  parameter int unsigned TIMEOUT_CYC = 16000000,
  parameter int unsigned RESET_VAL   = 32'hDEAD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sample_ready_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [1:0]        sel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] avg_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic [LOG2_N:0]   count_o,
  output logic [DATA_W-1:0] disp_o
);

  localparam int unsigned SUM_W = DATA_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  N_SAMPLES = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [DATA_W-1:0] RST_V     = DATA_W'(RESET_VAL);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              full, tmo_hit, accept;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    avg_d   = avg_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    full    = (cnt_q == N_SAMPLES);
    tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);
    // Rising edge of sample_ready only; the start cycle swallows any edge.
    accept  = (state_q == S_ACQ) && !start_i && sample_ready_i && !rdy_q && !full;

    if (start_i) begin
      state_d = S_ACQ;
      sum_d   = '0;
      min_d   = '1;
      max_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == S_ACQ) begin
      if (full) begin
        state_d = S_DONE;
        avg_d   = sum_q[SUM_W-1:LOG2_N];
      end else if (accept) begin
        sum_d = sum_q + SUM_W'(sample_i);
        if (sample_i < min_q) min_d = sample_i;
        if (sample_i > max_q) max_d = sample_i;
        cnt_d = cnt_q + CNT_W'(1);
        tmo_d = '0;
      end else if (tmo_hit) begin
        state_d = S_DONE;
        err_d   = 1'b1;
        avg_d   = sum_q[SUM_W-1:LOG2_N];
      end else if (TIMEOUT_CYC != 0) begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (sel_i)
      2'd0:    disp_d = avg_q;
      2'd1:    disp_d = min_q;
      2'd2:    disp_d = max_q;
      default: disp_d = DATA_W'(cnt_q);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      sum_q   <= '0;
      min_q   <= RST_V;
      max_q   <= RST_V;
      avg_q   <= RST_V;
      disp_q  <= RST_V;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= sample_ready_i;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      avg_q   <= avg_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign busy_o  = (state_q == S_ACQ);
  assign done_o  = (state_q == S_DONE);
  assign err_o   = err_q;
  assign avg_o   = avg_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign count_o = cnt_q;
  assign disp_o  = disp_q;

endmodule

// File: tb/tb_delay_stats_acc.sv
// tb/tb_delay_stats_acc.sv - randomized self-checking bench for delay_stats_acc (N=4/T=100 and defaults)
module tb_delay_stats_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 0, rdy_a = 0;
  logic [15:0] sample_a = 0;
  logic [1:0]  sel_a = 0;
  logic        busy_a, done_a, err_a;
  logic [15:0] avg_a, min_a, max_a, disp_a;
  logic [2:0]  count_a;

  logic        start_b = 0, rdy_b = 0;
  logic [15:0] sample_b = 0;
  logic [1:0]  sel_b = 0;
  logic        busy_b, done_b, err_b;
  logic [15:0] avg_b, min_b, max_b, disp_b;
  logic [10:0] count_b;

  delay_stats_acc #(.DATA_W(16), .LOG2_N(2), .TIMEOUT_CYC(100), .RESET_VAL(32'hDEAD)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .sample_ready_i(rdy_a), .sample_i(sample_a),
    .sel_i(sel_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .avg_o(avg_a),
    .min_o(min_a), .max_o(max_a), .count_o(count_a), .disp_o(disp_a));

  delay_stats_acc dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .sample_ready_i(rdy_b), .sample_i(sample_b),
    .sel_i(sel_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .avg_o(avg_b),
    .min_o(min_b), .max_o(max_b), .count_o(count_b), .disp_o(disp_b));

  logic [53:0] st_a;
  logic [61:0] st_b;
  assign st_a = {busy_a, done_a, err_a, count_a, avg_a, min_a, max_a};
  assign st_b = {busy_b, done_b, err_b, count_b, avg_b, min_b, max_b};

  int checks = 0;
  int failures = 0;
  logic [15:0] acc[$];
  logic [15:0] hold_avg_a = 16'hDEAD;
  logic [15:0] hold_avg_b = 16'hDEAD;

  // Reference results from the list of samples the current run has accepted.
  function automatic logic [15:0] mdl_avg(input int lg);
    longint unsigned s = 0;
    foreach (acc[i]) s += 64'(acc[i]);
    return 16'(s / (64'd1 << lg));
  endfunction

  function automatic logic [15:0] mdl_min();
    logic [15:0] m = 16'hFFFF;
    foreach (acc[i]) if (acc[i] < m) m = acc[i];
    return m;
  endfunction

  function automatic logic [15:0] mdl_max();
    logic [15:0] m = 16'h0000;
    foreach (acc[i]) if (acc[i] > m) m = acc[i];
    return m;
  endfunction

  task automatic start_pulse_a();
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    acc.delete();
  endtask

  task automatic start_pulse_b();
    @(negedge clk); start_b = 1;
    @(negedge clk); start_b = 0;
    acc.delete();
  endtask

  task automatic send_a(input logic [15:0] v, input int gap, input bit counted);
    @(negedge clk); sample_a = v; rdy_a = 1;
    if (counted) acc.push_back(v);
    @(negedge clk); rdy_a = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [15:0] v, input int gap);
    @(negedge clk); sample_b = v; rdy_b = 1;
    acc.push_back(v);
    @(negedge clk); rdy_b = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (st_a !== {3'b000, 3'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD}) begin
      failures++; $display("FAIL reset_a: got %h expected %h", st_a, {3'b000, 3'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD});
    end
    checks++;
    if (st_b !== {3'b000, 11'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD}) begin
      failures++; $display("FAIL reset_b: got %h expected %h", st_b, {3'b000, 11'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD});
    end
    checks++;
    if (disp_a !== 16'hDEAD) begin failures++; $display("FAIL reset_disp: got %h expected dead", disp_a); end
    rst = 0;
  endtask

  task automatic test_basic();
    logic [53:0] e;
    start_pulse_a();
    e = {3'b100, 3'd0, hold_avg_a, 16'hFFFF, 16'h0000};
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL basic_start: got %h expected %h", st_a, e); end
    send_a(16'd10, 2, 1);
    send_a(16'd20, 2, 1);
    send_a(16'd30, 2, 1);
    @(negedge clk); sample_a = 16'd40; rdy_a = 1; acc.push_back(16'd40);
    @(posedge clk); #1;
    e = {3'b100, 3'd4, hold_avg_a, mdl_min(), mdl_max()};
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL basic_accept4: got %h expected %h", st_a, e); end
    @(negedge clk); rdy_a = 0;
    @(posedge clk); #1;
    e = {3'b010, 3'd4, mdl_avg(2), mdl_min(), mdl_max()};
    checks++;
    if (st_a !== e || e !== {3'b010, 3'd4, 16'd25, 16'd10, 16'd40}) begin
      failures++; $display("FAIL basic_done: got %h expected %h", st_a, e);
    end
    hold_avg_a = mdl_avg(2);
  endtask

  task automatic test_disp();
    logic [15:0] d[4];
    d[0] = hold_avg_a; d[1] = mdl_min(); d[2] = mdl_max(); d[3] = 16'(acc.size());
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); sel_a = 2'(s); #1;
      if (s > 0) begin
        checks++;
        if (disp_a !== d[s-1]) begin failures++; $display("FAIL disp_lag%0d: got %h expected %h", s, disp_a, d[s-1]); end
      end
      @(posedge clk); #1;
      checks++;
      if (disp_a !== d[s]) begin failures++; $display("FAIL disp_sel%0d: got %h expected %h", s, disp_a, d[s]); end
    end
    @(negedge clk); sel_a = 0;
  endtask

  task automatic test_held();
    logic [53:0] e;
    start_pulse_a();
    @(negedge clk); sample_a = 16'd7; rdy_a = 1; acc.push_back(16'd7);
    repeat (50) @(negedge clk);
    rdy_a = 0;
    @(negedge clk);
    e = {3'b100, 3'd1, hold_avg_a, 16'd7, 16'd7};
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL held_single: got %h expected %h", st_a, e); end
    for (int i = 0; i < 3; i++) send_a(16'($urandom), 1, 1);
    e = {3'b010, 3'd4, mdl_avg(2), mdl_min(), mdl_max()};
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL held_done: got %h expected %h", st_a, e); end
    hold_avg_a = mdl_avg(2);
    send_a(16'd0, 1, 0);
    send_a(16'hFFFF, 1, 0);
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL extra_edges: got %h expected %h", st_a, e); end
  endtask

  task automatic test_timeout();
    logic [53:0] e;
    start_pulse_a();
    send_a(16'd8, 2, 1);
    @(negedge clk); sample_a = 16'd4; rdy_a = 1; acc.push_back(16'd4);
    @(posedge clk); #1; rdy_a = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 99) begin
        e = {3'b100, 3'd2, hold_avg_a, 16'd4, 16'd8};
        checks++;
        if (st_a !== e) begin failures++; $display("FAIL timeout_early: got %h expected %h", st_a, e); end
      end
    end
    e = {3'b011, 3'd2, mdl_avg(2), mdl_min(), mdl_max()};
    checks++;
    if (st_a !== e || mdl_avg(2) !== 16'd3) begin failures++; $display("FAIL timeout_done: got %h expected %h", st_a, e); end
    hold_avg_a = mdl_avg(2);
  endtask

  task automatic test_restart();
    logic [53:0] e;
    start_pulse_a();
    send_a(16'($urandom), 1, 1);
    send_a(16'($urandom), 1, 1);
    @(negedge clk); start_a = 1; rdy_a = 1; sample_a = 16'd99;
    acc.delete();
    @(negedge clk); start_a = 0;
    @(negedge clk); rdy_a = 0;
    e = {3'b100, 3'd0, hold_avg_a, 16'hFFFF, 16'h0000};
    checks++;
    if (st_a !== e) begin failures++; $display("FAIL restart_clear: got %h expected %h", st_a, e); end
    for (int i = 0; i < 4; i++) send_a(16'd1, 1, 1);
    e = {3'b010, 3'd4, mdl_avg(2), mdl_min(), mdl_max()};
    checks++;
    if (st_a !== e || e[47:0] !== {16'd1, 16'd1, 16'd1}) begin failures++; $display("FAIL restart_done: got %h expected %h", st_a, e); end
    hold_avg_a = mdl_avg(2);
  endtask

  task automatic test_random();
    logic [53:0] e;
    for (int r = 0; r < 12; r++) begin
      int n;
      int w;
      bit full_run;
      n = $urandom_range(0, 3);
      full_run = ($urandom_range(0, 2) != 0);
      start_pulse_a();
      if (full_run) begin
        for (int i = 0; i < 4; i++) send_a(16'($urandom), $urandom_range(1, 4), 1);
        e = {3'b010, 3'd4, mdl_avg(2), mdl_min(), mdl_max()};
      end else begin
        for (int i = 0; i < n; i++) send_a(16'($urandom), $urandom_range(1, 4), 1);
        w = 0;
        while (!done_a && w < 200) begin @(posedge clk); #1; w++; end
        e = {3'b011, 3'(n), mdl_avg(2), mdl_min(), mdl_max()};
      end
      checks++;
      if (st_a !== e) begin failures++; $display("FAIL random_run%0d: got %h expected %h", r, st_a, e); end
      hold_avg_a = mdl_avg(2);
    end
  endtask

  task automatic test_async_reset();
    start_pulse_a();
    send_a(16'd123, 1, 1);
    @(posedge clk); #3; rst = 1; #1;
    checks++;
    if (st_a !== {3'b000, 3'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD} || disp_a !== 16'hDEAD) begin
      failures++; $display("FAIL async_reset: got %h/%h expected reset values", st_a, disp_a);
    end
    @(negedge clk); rst = 0;
    hold_avg_a = 16'hDEAD; hold_avg_b = 16'hDEAD;
    repeat (5) @(negedge clk);
    checks++;
    if (st_a !== {3'b000, 3'd0, 16'hDEAD, 16'hDEAD, 16'hDEAD}) begin
      failures++; $display("FAIL post_reset_idle: got %h expected idle reset values", st_a);
    end
  endtask

  task automatic test_defaults();
    logic [61:0] e;
    start_pulse_b();
    for (int i = 0; i < 1024; i++) send_b(16'hFFFF, 1);
    e = {3'b010, 11'd1024, mdl_avg(10), mdl_min(), mdl_max()};
    checks++;
    if (st_b !== e || e[47:32] !== 16'hFFFF) begin failures++; $display("FAIL full_scale: got %h expected %h", st_b, e); end
    start_pulse_b();
    for (int i = 0; i < 1024; i++) send_b((i % 2) ? 16'hFFFF : 16'h0000, 1);
    e = {3'b010, 11'd1024, mdl_avg(10), mdl_min(), mdl_max()};
    checks++;
    if (st_b !== e || e[47:0] !== {16'h7FFF, 16'h0000, 16'hFFFF}) begin failures++; $display("FAIL alternating: got %h expected %h", st_b, e); end
    start_pulse_b();
    for (int i = 0; i < 1024; i++) send_b(16'($urandom), $urandom_range(1, 2));
    e = {3'b010, 11'd1024, mdl_avg(10), mdl_min(), mdl_max()};
    checks++;
    if (st_b !== e) begin failures++; $display("FAIL random_1024: got %h expected %h", st_b, e); end
    hold_avg_b = mdl_avg(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disp();
    test_held();
    test_timeout();
    test_restart();
    test_random();
    test_async_reset();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
